// File: rtl/neander_mem_responder_pkg.sv
// Shared types and sizing for the Neander memory responder slice.
// Every file of the slice imports this package.
package neander_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/neander_mem_responder_if.sv
// CPU request/ack bus plus the host-load port of the memory responder.
// The master side is the CPU/host; the slave side is the responder.
interface neander_mem_responder_if;

  logic                            req;
  logic                            we;
  logic [neander_pkg::ADDR_W-1:0]  addr;
  logic [neander_pkg::DATA_W-1:0]  wdata;
  logic                            ack;
  logic [neander_pkg::DATA_W-1:0]  rdata;
  logic                            busy;
  logic                            ld_en;
  logic [neander_pkg::ADDR_W-1:0]  ld_addr;
  logic [neander_pkg::DATA_W-1:0]  ld_data;
  logic                            ld_busy;

  modport master (
    output req, we, addr, wdata, ld_en, ld_addr, ld_data,
    input  ack, rdata, busy, ld_busy
  );

  modport slave (
    input  req, we, addr, wdata, ld_en, ld_addr, ld_data,
    output ack, rdata, busy, ld_busy
  );

endinterface

// File: rtl/neander_mem_responder_ram256.sv
// 256-byte storage: one synchronous write port and one asynchronous read port.
// clr wipes the whole array only when INIT_ZERO is set; writes are blocked while clr is high.
module neander_ram256
  import neander_pkg::*;
#(
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      if (INIT_ZERO != 0) begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
          mem[i] <= '0;
        end
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neander_mem_responder.sv
// Memory responder for the Neander CPU: fixed-latency request/ack with a host-load port.
// The CPU always wins arbitration; a refused host write is flagged on ld_busy.
module neander_mem_responder
  import neander_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  neander_mem_responder_if.slave bus
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              accept;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state == ACK && !we_q) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAST_WAIT) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The CPU write retires on the edge ending ACK; host loads only slip in when IDLE and unrequested.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = wdata_q;
    if (state == ACK && we_q) begin
      ram_we = 1'b1;
    end else if (state == IDLE && !bus.req && bus.ld_en) begin
      ram_we    = 1'b1;
      ram_waddr = bus.ld_addr;
      ram_wdata = bus.ld_data;
    end
  end

  neander_ram256 #(
    .INIT_ZERO(INIT_ZERO)
  ) u_ram (
    .clk  (clk),
    .clr  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(addr_q),
    .rdata(ram_rdata)
  );

  assign bus.ack     = (state == ACK);
  assign bus.busy    = (state != IDLE);
  assign bus.ld_busy = bus.ld_en && !rst && (bus.req || state != IDLE);
  assign bus.rdata   = (state == ACK && !we_q) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_neander_mem_responder.sv
// Bench for neander_mem_responder: dut 0 runs WAIT_CYCLES=2/INIT_ZERO=0, dut 1 runs WAIT_CYCLES=0/INIT_ZERO=1.
// A cycle-numbered transaction model is compared against both DUTs every cycle, plus literal checks.
module tb_neander_mem_responder;
  import neander_pkg::*;

  logic clk;
  logic rst;
  bit   checking;
  int   compared;
  int   mismatched;
  int   cyc;

  logic       req_v[2], we_v[2], ld_en_v[2];
  logic [7:0] addr_v[2], wdata_v[2], ld_addr_v[2], ld_data_v[2];
  logic       ack_v[2], busy_v[2], ld_busy_v[2];
  logic [7:0] rdata_v[2];

  bit         inflight[2];
  int         ack_cyc[2];
  logic       m_we[2];
  logic [7:0] m_addr[2], m_wdata[2], rhold[2];
  logic [7:0] mem_m[2][256];

  neander_mem_responder_if ifa();
  neander_mem_responder_if ifb();

  assign ifa.req = req_v[0];   assign ifb.req = req_v[1];
  assign ifa.we = we_v[0];     assign ifb.we = we_v[1];
  assign ifa.addr = addr_v[0]; assign ifb.addr = addr_v[1];
  assign ifa.wdata = wdata_v[0];     assign ifb.wdata = wdata_v[1];
  assign ifa.ld_en = ld_en_v[0];     assign ifb.ld_en = ld_en_v[1];
  assign ifa.ld_addr = ld_addr_v[0]; assign ifb.ld_addr = ld_addr_v[1];
  assign ifa.ld_data = ld_data_v[0]; assign ifb.ld_data = ld_data_v[1];
  assign ack_v[0] = ifa.ack;         assign ack_v[1] = ifb.ack;
  assign busy_v[0] = ifa.busy;       assign busy_v[1] = ifb.busy;
  assign ld_busy_v[0] = ifa.ld_busy; assign ld_busy_v[1] = ifb.ld_busy;
  assign rdata_v[0] = ifa.rdata;     assign rdata_v[1] = ifb.rdata;

  neander_mem_responder #(.WAIT_CYCLES(2), .INIT_ZERO(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  neander_mem_responder #(.WAIT_CYCLES(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int waitOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit initZeroOf(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input logic rq, input logic w, input logic [7:0] a,
                               input logic [7:0] wd, input logic le, input logic [7:0] la,
                               input logic [7:0] ldat);
    @(negedge clk);
    req_v[d] = rq;    we_v[d] = w;        addr_v[d] = a;     wdata_v[d] = wd;
    ld_en_v[d] = le;  ld_addr_v[d] = la;  ld_data_v[d] = ldat;
  endtask

  task automatic hostLoad(input int d, input logic [7:0] a, input logic [7:0] v);
    applyStimulus(d, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a, v);
  endtask

  // Issue one request, scramble the CPU inputs while it is in flight, and time the ack.
  task automatic cpuTxn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] alt, input logic hold_ld,
                        output int lat, output logic [7:0] rd, output logic lb);
    lat = -1;
    rd  = 8'h00;
    applyStimulus(d, 1'b1, w, a, wd, hold_ld, 8'h20, 8'h77);
    #2 lb = ld_busy_v[d];
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      applyStimulus(d, 1'b0, ~w, alt, ~wd, hold_ld, 8'h20, 8'h77);
      #2;
      if (ack_v[d]) begin
        lat = n;
        rd  = rdata_v[d];
      end
    end
    applyStimulus(d, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    #2 checkOutput($sformatf("d%0d_ack_width", d), {7'b0, ack_v[d]}, 8'h00);
  endtask

  // Transaction model: cycle c is the interval after the c-th rising edge.
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      inflight[d] = 1'b0; ack_cyc[d] = 0; m_we[d] = 1'b0;
      m_addr[d] = 8'h00;  m_wdata[d] = 8'h00; rhold[d] = 8'h00;
      for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          inflight[d] = 1'b0;
          rhold[d]    = 8'h00;
          if (initZeroOf(d)) for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
        end else if (inflight[d]) begin
          if (cyc == ack_cyc[d]) begin
            if (m_we[d]) mem_m[d][m_addr[d]] = m_wdata[d];
            else         rhold[d] = mem_m[d][m_addr[d]];
            inflight[d] = 1'b0;
          end
        end else if (req_v[d]) begin
          inflight[d] = 1'b1;
          m_we[d]     = we_v[d];
          m_addr[d]   = addr_v[d];
          m_wdata[d]  = wdata_v[d];
          ack_cyc[d]  = cyc + 1 + waitOf(d);
        end else if (ld_en_v[d]) begin
          mem_m[d][ld_addr_v[d]] = ld_data_v[d];
        end
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    logic       eack;
    logic [7:0] erd;
    forever begin
      @(negedge clk);
      #2;
      if (checking) begin
        for (int d = 0; d < 2; d++) begin
          eack = inflight[d] && (cyc == ack_cyc[d]);
          erd  = (eack && !m_we[d]) ? mem_m[d][m_addr[d]] : rhold[d];
          checkOutput($sformatf("d%0d_ack", d),  {7'b0, ack_v[d]},  {7'b0, eack});
          checkOutput($sformatf("d%0d_busy", d), {7'b0, busy_v[d]}, {7'b0, inflight[d]});
          checkOutput($sformatf("d%0d_rdata", d), rdata_v[d], erd);
          checkOutput($sformatf("d%0d_ld_busy", d), {7'b0, ld_busy_v[d]},
                      {7'b0, ld_en_v[d] && !rst && (req_v[d] || inflight[d])});
        end
      end
    end
  end

  initial begin
    int         lat;
    logic [7:0] rd;
    logic       lb;
    compared = 0;
    mismatched = 0;
    checking = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 0; we_v[d] = 0; addr_v[d] = 0; wdata_v[d] = 0;
      ld_en_v[d] = 0; ld_addr_v[d] = 0; ld_data_v[d] = 0;
    end
    repeat (2) @(negedge clk);
    checking = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_rst_ack", d),   {7'b0, ack_v[d]},  8'h00);
      checkOutput($sformatf("d%0d_rst_busy", d),  {7'b0, busy_v[d]}, 8'h00);
      checkOutput($sformatf("d%0d_rst_rdata", d), rdata_v[d],        8'h00);
    end
    rst = 1'b0;

    hostLoad(0, 8'h00, 8'h11);
    hostLoad(0, 8'h05, 8'h44);
    hostLoad(0, 8'h10, 8'h5A);
    hostLoad(0, 8'h11, 8'h6B);
    hostLoad(0, 8'h20, 8'h33);
    hostLoad(0, 8'hFF, 8'h00);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

    cpuTxn(0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, lat, rd, lb);
    checkOutput("read_latency", 8'(lat), 8'd3);
    checkOutput("read_0x10", rd, 8'h5A);

    cpuTxn(0, 1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0, lat, rd, lb);
    checkOutput("write_latency", 8'(lat), 8'd3);
    cpuTxn(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, lat, rd, lb);
    checkOutput("raw_0xFF", rd, 8'hC3);
    cpuTxn(0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, lat, rd, lb);
    checkOutput("addr0_unchanged", rd, 8'h11);

    cpuTxn(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, lat, rd, lb);
    checkOutput("collision_ld_busy", {7'b0, lb}, 8'h01);
    cpuTxn(0, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0, lat, rd, lb);
    checkOutput("collision_kept", rd, 8'h33);

    cpuTxn(0, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, lat, rd, lb);
    checkOutput("stable_addr", rd, 8'h5A);

    applyStimulus(0, 1'b1, 1'b1, 8'h05, 8'h99, 1'b0, 8'h00, 8'h00);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    #2;
    checkOutput("abort_busy",  {7'b0, busy_v[0]}, 8'h00);
    checkOutput("abort_rdata", rdata_v[0],        8'h00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      #2 checkOutput("abort_no_ack", {7'b0, ack_v[0]}, 8'h00);
    end
    cpuTxn(0, 1'b0, 8'h05, 8'h00, 8'h05, 1'b0, lat, rd, lb);
    checkOutput("abort_mem_kept", rd, 8'h44);

    cpuTxn(1, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, lat, rd, lb);
    checkOutput("zero_latency", 8'(lat), 8'd1);
    checkOutput("init_zero", rd, 8'h00);
    hostLoad(1, 8'h01, 8'hA1);
    hostLoad(1, 8'h02, 8'hB2);
    applyStimulus(1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 8'h00);
    #2 checkOutput("b2b_ack1", {7'b0, ack_v[1]}, 8'h01);
    checkOutput("b2b_rdata1", rdata_v[1], 8'hA1);
    applyStimulus(1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 8'h00);
    #2 checkOutput("b2b_gap", {7'b0, ack_v[1]}, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    #2 checkOutput("b2b_ack2", {7'b0, ack_v[1]}, 8'h01);
    checkOutput("b2b_rdata2", rdata_v[1], 8'hB2);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    #2 checkOutput("b2b_ack2_width", {7'b0, ack_v[1]}, 8'h00);

    cpuTxn(1, 1'b1, 8'h80, 8'h5C, 8'h80, 1'b0, lat, rd, lb);
    cpuTxn(1, 1'b0, 8'h80, 8'h00, 8'h81, 1'b0, lat, rd, lb);
    checkOutput("b_raw_0x80", rd, 8'h5C);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
